// File: rtl/matrix_pkg.sv
// Shared definitions for the 2x2 matrix multiplier driver, its responder and the bench.
package matrix_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned RW_DEF = 16;
  localparam int unsigned N_ELEM = 4;

  // Element slot within a packed {x11,x12,x21,x22} word; slot s occupies [s*W +: W].
  localparam int unsigned IDX_11 = 3;
  localparam int unsigned IDX_12 = 2;
  localparam int unsigned IDX_21 = 1;
  localparam int unsigned IDX_22 = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } drv_state_e;

endpackage

// File: rtl/matrix_mul_2x2_seq.sv
// Sequential 2x2 multiplier: one result element per cycle after start, then a one-cycle done pulse.
module matrix_mul_2x2_seq
  import matrix_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned RW = RW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N_ELEM*DW-1:0] a,
  input  logic [N_ELEM*DW-1:0] b,
  output logic [N_ELEM*RW-1:0] c,
  output logic                 done
);

  logic                 busy_q, busy_d;
  logic [1:0]           idx_q, idx_d;
  logic [N_ELEM*RW-1:0] c_q, c_d;
  logic                 done_q, done_d;
  logic [RW-1:0]        dot;
  int unsigned          pos_a1, pos_a2, pos_b1, pos_b2, pos_c;

  function automatic logic [DW-1:0] el(input logic [N_ELEM*DW-1:0] m, input int unsigned s);
    return m[s*DW +: DW];
  endfunction

  // idx = {row, col}; dot product of row of a with column of b.
  always_comb begin
    pos_a1 = IDX_11 - 2 * 32'(idx_q[1]);
    pos_a2 = IDX_12 - 2 * 32'(idx_q[1]);
    pos_b1 = IDX_11 - 32'(idx_q[0]);
    pos_b2 = IDX_21 - 32'(idx_q[0]);
    pos_c  = IDX_11 - 32'(idx_q);
    dot    = RW'(el(a, pos_a1)) * RW'(el(b, pos_b1))
           + RW'(el(a, pos_a2)) * RW'(el(b, pos_b2));
  end

  always_comb begin
    busy_d = busy_q;
    idx_d  = idx_q;
    c_d    = c_q;
    done_d = 1'b0;
    if (!busy_q) begin
      if (start) begin
        busy_d = 1'b1;
        idx_d  = 2'd0;
      end
    end else begin
      c_d[pos_c*RW +: RW] = dot;
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      idx_q  <= 2'd0;
      c_q    <= '0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      idx_q  <= idx_d;
      c_q    <= c_d;
      done_q <= done_d;
    end
  end

  assign c    = c_q;
  assign done = done_q;

endmodule

// File: rtl/matrix_mul_2x2_driver.sv
// Initiator for matrix_mul_2x2_seq: accepts a job, pulses start, waits for done or timeout,
// and presents the captured result on a valid/ready stream.
module matrix_mul_2x2_driver
  import matrix_pkg::*;
#(
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned RW      = RW_DEF,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_ELEM*DW-1:0] in_a,
  input  logic [N_ELEM*DW-1:0] in_b,
  output logic                 mul_start,
  output logic [N_ELEM*DW-1:0] mul_a,
  output logic [N_ELEM*DW-1:0] mul_b,
  input  logic [N_ELEM*RW-1:0] mul_c,
  input  logic                 mul_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_ELEM*RW-1:0] out_c,
  output logic                 out_err,
  output logic [15:0]          job_cnt
);

  localparam int unsigned CW   = 16;
  localparam int unsigned TMAX = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam int unsigned TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

  drv_state_e           state_q, state_d;
  logic [N_ELEM*DW-1:0] mul_a_q, mul_a_d;
  logic [N_ELEM*DW-1:0] mul_b_q, mul_b_d;
  logic [N_ELEM*RW-1:0] out_c_q, out_c_d;
  logic                 out_err_q, out_err_d;
  logic [CW-1:0]        job_cnt_q, job_cnt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 in_ready_q, mul_start_q, out_valid_q;
  logic                 timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (timer_q == TW'(TMAX));

  // Next-state and datapath; mul_done is deliberately not looked at in ISSUE.
  always_comb begin
    state_d   = state_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    out_c_d   = out_c_q;
    out_err_d = out_err_q;
    job_cnt_d = job_cnt_q;
    timer_d   = timer_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mul_a_d = in_a;
          mul_b_d = in_b;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mul_done) begin
          out_c_d   = mul_c;
          out_err_d = 1'b0;
          state_d   = HOLD;
        end else if (timeout_hit) begin
          out_c_d   = '0;
          out_err_d = 1'b1;
          state_d   = HOLD;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          job_cnt_d = job_cnt_q + CW'(1);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      out_c_q     <= '0;
      out_err_q   <= 1'b0;
      job_cnt_q   <= '0;
      timer_q     <= '0;
      in_ready_q  <= 1'b1;
      mul_start_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      out_c_q     <= out_c_d;
      out_err_q   <= out_err_d;
      job_cnt_q   <= job_cnt_d;
      timer_q     <= timer_d;
      in_ready_q  <= (state_d == IDLE);
      mul_start_q <= (state_d == ISSUE);
      out_valid_q <= (state_d == HOLD);
    end
  end

  assign in_ready  = in_ready_q;
  assign mul_start = mul_start_q;
  assign out_valid = out_valid_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_c     = out_c_q;
  assign out_err   = out_err_q;
  assign job_cnt   = job_cnt_q;

endmodule
